// File: rtl/mod_counter.sv
// Up/down modulo counter with parallel load, programmable limit and
// selectable wrap/saturate behaviour at the count boundaries.
module mod_counter #(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             direction,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] counter_out,
   output logic             tc,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_r;
   logic             tc_r;
   logic             ovf_r;

   logic [WIDTH-1:0] next_count_s;
   logic             next_tc_s;
   logic             next_ovf_s;

   // Next-state selection: load beats enable; tc is a one-cycle pulse by default
   always_comb begin
      next_count_s = count_r;
      next_tc_s    = 1'b0;
      next_ovf_s   = ovf_r;
      if (load) begin
         next_count_s = load_value;
         next_ovf_s   = 1'b0;
      end else if (enable) begin
         if (direction) begin
            // Counts at or above the limit (e.g. after an over-range load) hit the boundary
            if (count_r < limit) begin
               next_count_s = count_r + ONE;
            end else begin
               next_count_s = SATURATE ? limit : ZERO;
               next_tc_s    = 1'b1;
               next_ovf_s   = 1'b1;
            end
         end else begin
            if (count_r != ZERO) begin
               next_count_s = count_r - ONE;
            end else begin
               next_count_s = SATURATE ? ZERO : limit;
               next_tc_s    = 1'b1;
               next_ovf_s   = 1'b1;
            end
         end
      end else begin
         next_count_s = count_r;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= ZERO;
         tc_r    <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         count_r <= next_count_s;
         tc_r    <= next_tc_s;
         ovf_r   <= next_ovf_s;
      end
   end

   assign counter_out = count_r;
   assign tc          = tc_r;
   assign ovf         = ovf_r;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed vector table on a wrapping and
// a saturating instance, a reset-abort sequence, then random stimulus vs a model.
module tb_mod_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       enable = 1'b0;
   logic       direction = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_value = 8'd0;
   logic [7:0] limit = 8'd0;
   logic [7:0] cnt_w, cnt_s;
   logic       tc_w, tc_s, ovf_w, ovf_s;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mod_counter #(.WIDTH(8), .SATURATE(1'b0)) dut_w (
      .clk(clk), .rst(rst), .enable(enable), .direction(direction), .load(load),
      .load_value(load_value), .limit(limit), .counter_out(cnt_w), .tc(tc_w), .ovf(ovf_w));

   mod_counter #(.WIDTH(8), .SATURATE(1'b1)) dut_s (
      .clk(clk), .rst(rst), .enable(enable), .direction(direction), .load(load),
      .load_value(load_value), .limit(limit), .counter_out(cnt_s), .tc(tc_s), .ovf(ovf_s));

   typedef struct {
      logic       rst, ld, en, dir;
      logic [7:0] lv, lim;
      logic       sat;
      logic [7:0] ec;
      logic       et, eo;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic l, logic e, logic d, logic [7:0] lv,
                               logic [7:0] lim, logic sat, logic [7:0] ec, logic et, logic eo);
      vec_t v;
      v.rst = r; v.ld = l; v.en = e; v.dir = d; v.lv = lv; v.lim = lim;
      v.sat = sat; v.ec = ec; v.et = et; v.eo = eo;
      return v;
   endfunction

   function automatic void add(logic r, logic l, logic e, logic d, logic [7:0] lv,
                               logic [7:0] lim, logic sat, logic [7:0] ec, logic et, logic eo);
      tbl.push_back(mk(r, l, e, d, lv, lim, sat, ec, et, eo));
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one vector, let one edge pass, compare the selected instance
   task automatic apply(vec_t v, string tag);
      rst = v.rst; load = v.ld; enable = v.en; direction = v.dir;
      load_value = v.lv; limit = v.lim;
      @(posedge clk);
      #1;
      if (v.sat) begin
         chk({tag, "_cnt_sat"}, {24'd0, cnt_s}, {24'd0, v.ec});
         chk({tag, "_tc_sat"},  {31'd0, tc_s},  {31'd0, v.et});
         chk({tag, "_ovf_sat"}, {31'd0, ovf_s}, {31'd0, v.eo});
      end else begin
         chk({tag, "_cnt_wrap"}, {24'd0, cnt_w}, {24'd0, v.ec});
         chk({tag, "_tc_wrap"},  {31'd0, tc_w},  {31'd0, v.et});
         chk({tag, "_ovf_wrap"}, {31'd0, ovf_w}, {31'd0, v.eo});
      end
   endtask

   // Reference behaviour, written directly from the counting rules
   function automatic void model(input bit sat, input bit r, input bit l, input bit e,
                                 input bit d, input int lv, input int lim,
                                 inout int c, inout bit t, inout bit o);
      if (r) begin
         c = 0; t = 1'b0; o = 1'b0;
      end else if (l) begin
         c = lv; t = 1'b0; o = 1'b0;
      end else if (!e) begin
         t = 1'b0;
      end else if (d) begin
         if (c < lim) begin
            c = c + 1; t = 1'b0;
         end else begin
            c = sat ? lim : 0; t = 1'b1; o = 1'b1;
         end
      end else begin
         if (c > 0) begin
            c = c - 1; t = 1'b0;
         end else begin
            c = sat ? 0 : lim; t = 1'b1; o = 1'b1;
         end
      end
   endfunction

   initial begin
      int mc0, mc1;
      bit mt0, mt1, mo0, mo1;
      bit r, l, e, d;
      int lv, lim;

      // Wrap instance: reset priority, count to 9 and wrap, hold, toggle direction
      add(1'b1, 1'b1, 1'b1, 1'b1, 8'd55, 8'd9, 1'b0, 8'd0, 1'b0, 1'b0);
      for (int i = 1; i <= 9; i++)
         add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd9, 1'b0, 8'(i), 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd9, 1'b0, 8'd0, 1'b1, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd9, 1'b0, 8'd1, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd9, 1'b0, 8'd2, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd9, 1'b0, 8'd3, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++)
         add(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd9, 1'b0, 8'd3, 1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 8'd9, 1'b0, 8'd4, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd9, 1'b0, 8'd5, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 8'd4, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd9, 1'b0, 8'd5, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd9, 1'b0, 8'd4, 1'b0, 1'b0);
      // Over-range load, up then down
      add(1'b0, 1'b1, 1'b0, 1'b1, 8'd200, 8'd100, 1'b0, 8'd200, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd100, 1'b0, 8'd0,   1'b1, 1'b1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'd200, 8'd100, 1'b0, 8'd200, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd100, 1'b0, 8'd199, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd100, 1'b0, 8'd198, 1'b0, 1'b0);
      // Limit zero
      add(1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
      // All-ones value wraps only through the boundary, then a limit change
      add(1'b0, 1'b1, 1'b0, 1'b1, 8'd255, 8'd255, 1'b0, 8'd255, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd255, 1'b0, 8'd0,   1'b1, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd255, 1'b0, 8'd1,   1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd1,   1'b0, 8'd0,   1'b1, 1'b1);
      // Saturating instance
      add(1'b1, 1'b1, 1'b1, 1'b0, 8'd9, 8'd5, 1'b1, 8'd0, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'd7, 8'd5, 1'b1, 8'd7, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd5, 1'b1, 8'd2, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd5, 1'b1, 8'd1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd5, 1'b1, 8'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         add(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd5, 1'b1, 8'd0, 1'b1, 1'b1);
      add(1'b0, 1'b1, 1'b0, 1'b1, 8'd200, 8'd100, 1'b1, 8'd200, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd100, 1'b1, 8'd100, 1'b1, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd100, 1'b1, 8'd100, 1'b1, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   8'd100, 1'b1, 8'd99,  1'b0, 1'b1);
      add(1'b0, 1'b1, 1'b0, 1'b1, 8'd255, 8'd255, 1'b1, 8'd255, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd255, 1'b1, 8'd255, 1'b1, 1'b1);

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("vec%0d", i));

      // Reset mid-count aborts the count; counting resumes from 0
      apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 8'd9, 1'b0, 8'd2, 1'b0, 1'b0), "abort_load");
      apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd9, 1'b0, 8'd3, 1'b0, 1'b0), "abort_cnt");
      apply(mk(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd9, 1'b0, 8'd0, 1'b0, 1'b0), "abort_rst");
      apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd9, 1'b0, 8'd0, 1'b0, 1'b0), "abort_idle");
      apply(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 8'd9, 1'b0, 8'd1, 1'b0, 1'b0), "abort_resume");

      // Random stimulus on both instances against the reference model
      mc0 = 0; mc1 = 0; mt0 = 1'b0; mt1 = 1'b0; mo0 = 1'b0; mo1 = 1'b0;
      for (int i = 0; i < 600; i++) begin
         r   = (i == 0) || ($urandom_range(0, 31) == 0);
         l   = ($urandom_range(0, 7) == 0);
         e   = ($urandom_range(0, 3) != 0);
         d   = 1'($urandom_range(0, 1));
         lv  = $urandom_range(0, 255);
         lim = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 255);
         rst = r; load = l; enable = e; direction = d;
         load_value = 8'(lv); limit = 8'(lim);
         model(1'b0, r, l, e, d, lv, lim, mc0, mt0, mo0);
         model(1'b1, r, l, e, d, lv, lim, mc1, mt1, mo1);
         @(posedge clk);
         #1;
         chk("rnd_cnt_wrap", {24'd0, cnt_w}, 32'(mc0));
         chk("rnd_tc_wrap",  {31'd0, tc_w},  {31'd0, mt0});
         chk("rnd_ovf_wrap", {31'd0, ovf_w}, {31'd0, mo0});
         chk("rnd_cnt_sat",  {24'd0, cnt_s}, 32'(mc1));
         chk("rnd_tc_sat",   {31'd0, tc_s},  {31'd0, mt1});
         chk("rnd_ovf_sat",  {31'd0, ovf_s}, {31'd0, mo1});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001: Parameter WIDTH, default 8, sets the bit width of the count and of the load and limit values (WIDTH >= 2).
REQ-002: Parameter SATURATE, default 0: 0 means wrap at the boundary; 1 means hold at the boundary.
REQ-003: clk  input  1  single clock; all state updates on the rising edge.
REQ-004: rst  input  1  synchronous, active-high reset.
REQ-005: enable  input  1  count enable; 0 holds the count.
REQ-006: direction  input  1  1 counts up, 0 counts down.
REQ-007: load  input  1  synchronous parallel load strobe.
REQ-008: load_value  input  WIDTH  value captured when load=1.
REQ-009: limit  input  WIDTH  upper count bound (modulus-1); sampled every cycle.
REQ-010: counter_out  output  WIDTH  registered count value.
REQ-011: tc  output  1  registered terminal-count pulse.
REQ-012: ovf  output  1  registered sticky boundary-crossing flag.

Function
REQ-013: Priority per rising edge SHALL be rst > load > enable > hold.
REQ-014: On load=1, counter_out SHALL take load_value unmodified on the next edge, even if it exceeds limit; tc SHALL be 0 and ovf SHALL clear.
REQ-015: With enable=0 and load=0, counter_out, tc and ovf SHALL hold, except tc SHALL drop to 0.
REQ-016: Up, counter_out < limit: next = counter_out+1, tc=0.
REQ-017: Up, counter_out >= limit, SATURATE=0: next = 0, tc=1, ovf=1.
REQ-018: Up, counter_out >= limit, SATURATE=1: next = limit, tc=1, ovf=1.
REQ-019: Down, counter_out > 0: next = counter_out-1, tc=0, including values above limit.
REQ-020: Down, counter_out == 0, SATURATE=0: next = limit, tc=1, ovf=1.
REQ-021: Down, counter_out == 0, SATURATE=1: next = 0, tc=1, ovf=1.
REQ-022: tc SHALL be high for exactly the one cycle following each boundary edge; repeated boundary edges in saturate mode SHALL keep tc high on every such cycle.
REQ-023: Latency SHALL be 1 cycle from input sample to counter_out, tc and ovf; there SHALL be no combinational path from any input to any output.
REQ-024: Arithmetic SHALL be WIDTH-bit modulo 2^WIDTH; the all-ones value SHALL count up only via the boundary rules.
REQ-025: With limit=0: up with wrap SHALL give 0 every cycle with tc=1; down SHALL give 0 with tc=1.
REQ-026: A direction change SHALL take effect on the same edge it is sampled, with no dead cycle.
REQ-027: A limit change SHALL take effect on the edge it is sampled; a count above the new limit obeys REQ-017/018/019.

Reset
REQ-028: When rst=1 at a rising edge: counter_out=0, tc=0, ovf=0, regardless of load or enable.
REQ-029: Reset asserted mid-count SHALL abort the count on that edge; counting resumes from 0 on the first edge with rst=0 and enable=1.
REQ-030: No state SHALL change asynchronously to clk.

Verification
REQ-031: WIDTH=8, SATURATE=0, limit=9, up, enable for 12 cycles from reset -> 1..9, 0, 1, 2; tc high only in the cycle after 9->0; ovf=1 from then on.
REQ-032: WIDTH=8, SATURATE=1, limit=5, down from load 2 for 5 cycles -> 1, 0, 0, 0, 0; tc high for the last three; ovf=1.
REQ-033: load_value=200, limit=100, up, SATURATE=0 -> next 0, tc=1; repeat with direction=0 -> 199, 198 with tc=0.
REQ-034: rst, load and enable all high in the same cycle -> counter_out=0, tc=0, ovf=0; then rst=0 with load=1, load_value=7 -> counter_out=7, ovf=0.
REQ-035: enable=0 for 4 cycles at count 3 after a wrap -> counter_out stays 3, ovf stays 1, tc=0 throughout.
REQ-036: Direction toggled every cycle from 4, limit=9 -> 5, 4, 5, 4; tc never asserts.
